// File: rtl/serial_adder.sv
// Bit-serial adder: one FA stage with a carry flop, LSB first, start/busy/done handshake.
// Result registers hold the last completed sum until the next RUN->DONE edge.

module FA (
    input  logic iA,
    input  logic iB,
    input  logic iC,
    output logic oS,
    output logic oC
);
    assign oS = iA ^ iB ^ iC;
    assign oC = (iA & iB) | (iC & (iA ^ iB));
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iCin,
    output logic [WIDTH-1:0] oSum,
    output logic             oCout,
    output logic             oOvf,
    output logic             oBusy,
    output logic             oDone
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, sh_q, sh_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q, busy_q, done_q;
    logic             fa_s, fa_c;

    FA u_fa (
        .iA (a_q[0]),
        .iB (b_q[0]),
        .iC (carry_q),
        .oS (fa_s),
        .oC (fa_c)
    );

    // Sum enters at the MSB so that after WIDTH shifts bit i holds sum bit i.
    always_comb begin
        sh_d = {fa_s, sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (iStart) begin
                        a_q     <= iA;
                        b_q     <= iB;
                        carry_q <= iCin;
                        cnt_q   <= '0;
                        sh_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_q     <= {1'b0, a_q[WIDTH-1:1]};
                    b_q     <= {1'b0, b_q[WIDTH-1:1]};
                    sh_q    <= sh_d;
                    carry_q <= fa_c;
                    cnt_q   <= cnt_q + 1'b1;
                    // carry_q here is the carry into the MSB
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_q   <= sh_d;
                        cout_q  <= fa_c;
                        ovf_q   <= carry_q ^ fa_c;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign oSum  = sum_q;
    assign oCout = cout_q;
    assign oOvf  = ovf_q;
    assign oBusy = busy_q;
    assign oDone = done_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): expected results queued at start, checked at oDone.

module tb_serial_adder;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic [7:0] sum;
    logic       cout, ovf, busy, done;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    serial_adder #(.WIDTH(8)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .iStart (start),
        .iA     (a),
        .iB     (b),
        .iCin   (cin),
        .oSum   (sum),
        .oCout  (cout),
        .oOvf   (ovf),
        .oBusy  (busy),
        .oDone  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a start for one cycle and queue its expected result; returns at the negedge after the start edge.
    task automatic do_start(input logic [7:0] ta, input logic [7:0] tb, input logic tc, input exp_t e);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic wait_done(output int busy_cycles, output bit seen);
        busy_cycles = 0;
        seen        = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            if (done) seen = 1'b1;
            else begin
                if (busy) busy_cycles++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sum, cout, ovf, busy, done} !== 12'h000) begin
            $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b busy=%b done=%b, need all 0", sum, cout, ovf, busy, done);
            errors++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [7:0] va[5];
        logic [7:0] vb[5];
        logic       vc[5];
        exp_t       ve[5];
        int         bc;
        bit         seen;
        exp_t       e;
        va[0] = 8'h5A; vb[0] = 8'h3C; vc[0] = 1'b0; ve[0] = '{8'h96, 1'b0, 1'b1};
        va[1] = 8'hFF; vb[1] = 8'h01; vc[1] = 1'b0; ve[1] = '{8'h00, 1'b1, 1'b0};
        va[2] = 8'hFF; vb[2] = 8'hFF; vc[2] = 1'b1; ve[2] = '{8'hFF, 1'b1, 1'b0};
        va[3] = 8'h80; vb[3] = 8'h80; vc[3] = 1'b0; ve[3] = '{8'h00, 1'b1, 1'b1};
        va[4] = 8'h00; vb[4] = 8'h00; vc[4] = 1'b1; ve[4] = '{8'h01, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            do_start(va[i], vb[i], vc[i], ve[i]);
            wait_done(bc, seen);
            checks++;
            if (!seen) begin
                $display("FAIL vec%0d_done_timeout: got no oDone, need oDone within 40 cycles", i);
                errors++;
                continue;
            end
            checks++;
            if (bc != 8) begin
                $display("FAIL vec%0d_busy_cycles: got %0d, need 8", i, bc);
                errors++;
            end
            e = sb.pop_front();
            checks++;
            if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin
                $display("FAIL vec%0d_result: got sum=%h cout=%b ovf=%b, need sum=%h cout=%b ovf=%b",
                         i, sum, cout, ovf, e.s, e.c, e.v);
                errors++;
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || sum !== e.s) begin
                $display("FAIL vec%0d_after_done: got done=%b sum=%h, need done=0 sum=%h", i, done, sum, e.s);
                errors++;
            end
        end
    endtask

    task automatic test_ignored_start();
        int   bc;
        bit   seen;
        int   extra;
        exp_t e;
        do_start(8'h12, 8'h34, 1'b0, '{8'h46, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, seen);
        checks++;
        if (!seen) begin
            $display("FAIL ignored_done_timeout: got no oDone, need oDone within 40 cycles");
            errors++;
        end else begin
            e = sb.pop_front();
            checks++;
            if ({sum, cout} !== {e.s, e.c}) begin
                $display("FAIL ignored_result: got sum=%h cout=%b, need sum=%h cout=%b", sum, cout, e.s, e.c);
                errors++;
            end
        end
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            $display("FAIL ignored_no_extra_run: got %0d busy/done cycles, need 0", extra);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int   cyc, last, ndone;
        exp_t e;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        repeat (3) sb.push_back('{8'h02, 1'b0, 1'b0});
        cyc = 0; last = 0; ndone = 0;
        for (int n = 0; n < 60 && ndone < 3; n++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                e = sb.pop_front();
                checks++;
                if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin
                    $display("FAIL b2b_result%0d: got sum=%h cout=%b ovf=%b, need sum=%h cout=%b ovf=%b",
                             ndone, sum, cout, ovf, e.s, e.c, e.v);
                    errors++;
                end
                if (ndone > 0) begin
                    checks++;
                    if (cyc - last != 10) begin
                        $display("FAIL b2b_spacing%0d: got %0d cycles, need 10", ndone, cyc - last);
                        errors++;
                    end
                end
                last = cyc;
                ndone++;
                if (ndone == 3) start = 1'b0;
            end else if (busy && ndone > 0) begin
                checks++;
                if (sum !== 8'h02) begin
                    $display("FAIL b2b_hold_in_run: got sum=%h, need 02", sum);
                    errors++;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 3) begin
            $display("FAIL b2b_done_count: got %0d, need 3", ndone);
            errors++;
        end
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int   bc;
        bit   seen;
        int   ndone;
        exp_t e;
        do_start(8'h5A, 8'h3C, 1'b0, '{8'h96, 1'b0, 1'b1});
        wait_done(bc, seen);
        e = sb.pop_front();
        checks++;
        if (!seen || sum !== e.s) begin
            $display("FAIL rst_pre_result: got seen=%b sum=%h, need seen=1 sum=%h", seen, sum, e.s);
            errors++;
        end
        repeat (2) @(negedge clk);
        do_start(8'h0F, 8'h01, 1'b0, '{8'h10, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checks++;
        if ({sum, cout, ovf, busy, done} !== 12'h000) begin
            $display("FAIL rst_mid_run: got sum=%h cout=%b ovf=%b busy=%b done=%b, need all 0", sum, cout, ovf, busy, done);
            errors++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            $display("FAIL rst_no_done: got %0d busy/done cycles, need 0", ndone);
            errors++;
        end
        do_start(8'h0F, 8'h01, 1'b0, '{8'h10, 1'b0, 1'b0});
        wait_done(bc, seen);
        checks++;
        if (!seen) begin
            $display("FAIL rst_post_timeout: got no oDone, need oDone within 40 cycles");
            errors++;
        end else begin
            e = sb.pop_front();
            checks++;
            if ({sum, cout, ovf} !== {e.s, e.c, e.v}) begin
                $display("FAIL rst_post_result: got sum=%h cout=%b ovf=%b, need sum=%h cout=%b ovf=%b",
                         sum, cout, ovf, e.s, e.c, e.v);
                errors++;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_empty: got %0d entries left, need 0", sb.size());
            errors++;
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_vectors();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
